ladybird_uart_tx: RTL and testbench

LADYBIRD_UART_TX -- requirements
Module: ladybird_uart_tx

---
 rtl/ladybird_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_ladybird_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_uart_tx.sv
// Byte-wide 8N1/8E1/8O1 (1 or 2 stop bits) UART transmitter with a valid/ready
// byte input and a registered, glitch-free serial output.
module ladybird_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    output logic       a_ready,
    output logic       txd,
    output logic       busy
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gBadClksPerBit
        $error("ladybird_uart_tx: CLKS_PER_BIT must be within 2..65535");
    end
    if (PARITY < 0 || PARITY > 2) begin : gBadParity
        $error("ladybird_uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
        $error("ladybird_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             PAR_INV   = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             txd_q, txd_d;
    logic             bitEnd;

    assign bitEnd  = (cnt_q == CNT_LAST);
    assign a_ready = (state_q == ST_IDLE) & ~rst;
    assign busy    = (state_q != ST_IDLE);
    assign txd     = txd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
        end
    end

    // txd_d is the level of the *next* bit, so the line register flips exactly on bit boundaries
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        txd_d    = txd_q;

        case (state_q)
            ST_IDLE: begin
                txd_d    = 1'b1;
                cnt_d    = '0;
                bitIdx_d = '0;
                if (a_valid && a_ready) begin
                    state_d  = ST_START;
                    shift_d  = a_data;
                    parity_d = 1'b0;
                    txd_d    = 1'b0;
                end
            end

            ST_START: begin
                if (bitEnd) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (bitEnd) begin
                    cnt_d    = '0;
                    shift_d  = {1'b0, shift_q[7:1]};
                    parity_d = parity_q ^ shift_q[0];
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = '0;
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            txd_d   = parity_q ^ shift_q[0] ^ PAR_INV;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        txd_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_PARITY: begin
                if (bitEnd) begin
                    state_d  = ST_STOP;
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    txd_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                txd_d = 1'b1;
                if (bitEnd) begin
                    cnt_d = '0;
                    if (bitIdx_q == STOP_LAST) begin
                        state_d  = ST_IDLE;
                        bitIdx_d = '0;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                bitIdx_d = '0;
                txd_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ladybird_uart_tx.sv
// Scoreboard bench for ladybird_uart_tx: four instances cover none/even/odd parity
// and two stop bits; a monitor decodes the selected line and checks against queued frames.
module tb_ladybird_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         parEn;
        int         stops;
        bit         b2b;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] aData  [4];
    logic       aValid [4];
    logic       aReady [4];
    logic       txdV   [4];
    logic       busyV  [4];

    int   sel;
    logic selTxd, selBusy, selReady;
    bit   monEn, monBusy;

    int parEnOf [4] = '{0, 1, 1, 0};
    int stopsOf [4] = '{1, 1, 1, 2};

    frame_t expQ[$];
    int     nChecks = 0;
    int     nMiss   = 0;

    logic rec      [0:63];
    logic recBusy  [0:63];
    logic recReady [0:63];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        localparam int P = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int S = (g == 3) ? 2 : 1;
        ladybird_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (P),
            .STOP_BITS   (S)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .a_data (aData[g]),
            .a_valid(aValid[g]),
            .a_ready(aReady[g]),
            .txd    (txdV[g]),
            .busy   (busyV[g])
        );
    end

    assign selTxd   = txdV[sel];
    assign selBusy  = busyV[sel];
    assign selReady = aReady[sel];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Queues the expected frame, waits (bounded) for a_ready, handshakes, then optionally
    // drops a_valid and scrambles a_data so a busy-time change would corrupt the frame.
    task automatic applyStimulus(input int s, input logic [7:0] d, input logic par,
                                 input bit b2b, input bit dropValid, input bit track,
                                 output int waited);
        frame_t r;
        if (track) begin
            r.data  = d;
            r.par   = par;
            r.parEn = parEnOf[s];
            r.stops = stopsOf[s];
            r.b2b   = b2b;
            expQ.push_back(r);
        end
        aData[s]  = d;
        aValid[s] = 1'b1;
        waited    = 0;
        while (aReady[s] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (aReady[s] !== 1'b1) begin
            checkOutput("a_ready wait timeout", 32'(aReady[s]), 1);
            aValid[s] = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("txd low cycle after handshake", 32'(txdV[s]), 0);
            checkOutput("busy cycle after handshake", 32'(busyV[s]), 1);
            if (dropValid) begin
                aValid[s] = 1'b0;
                aData[s]  = ~d;
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((expQ.size() != 0 || monBusy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkOutput("pending frames after drain", expQ.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        frame_t     r;
        int         len;
        logic [7:0] d;
        bit         stable, stopHigh, busyOk, readyOk, expectStart;
        expectStart = 1'b0;
        monBusy     = 1'b0;
        forever begin
            @(negedge clk);
            if (expectStart) begin
                checkOutput("single idle cycle between frames", 32'(selTxd), 0);
                expectStart = 1'b0;
            end
            if (monEn && selTxd == 1'b0) begin
                monBusy = 1'b1;
                if (expQ.size() == 0) begin
                    checkOutput("frame seen with queue depth", expQ.size(), 1);
                    for (int k = 0; k < 64 && selTxd == 1'b0; k++) @(negedge clk);
                end else begin
                    r   = expQ.pop_front();
                    len = (9 + r.parEn + r.stops) * CPB;
                    rec[0]      = selTxd;
                    recBusy[0]  = selBusy;
                    recReady[0] = selReady;
                    for (int c = 1; c <= len; c++) begin
                        @(negedge clk);
                        rec[c]      = selTxd;
                        recBusy[c]  = selBusy;
                        recReady[c] = selReady;
                    end
                    stable = 1'b1;
                    for (int c = 0; c < len; c++)
                        if (rec[c] !== rec[(c / CPB) * CPB]) stable = 1'b0;
                    for (int i = 0; i < 8; i++) d[i] = rec[(1 + i) * CPB + 1];
                    stopHigh = 1'b1;
                    for (int c = (9 + r.parEn) * CPB; c <= len; c++)
                        if (rec[c] !== 1'b1) stopHigh = 1'b0;
                    busyOk  = 1'b1;
                    readyOk = 1'b1;
                    for (int c = 0; c < len; c++) begin
                        if (recBusy[c] !== 1'b1) busyOk = 1'b0;
                        if (recReady[c] !== 1'b0) readyOk = 1'b0;
                    end
                    checkOutput("start bit", 32'(rec[1]), 0);
                    checkOutput("data byte", 32'(d), 32'(r.data));
                    if (r.parEn != 0) checkOutput("parity bit", 32'(rec[9 * CPB + 1]), 32'(r.par));
                    checkOutput("stop bits and idle high", 32'(stopHigh), 1);
                    checkOutput("bits held full period", 32'(stable), 1);
                    checkOutput("busy through frame", 32'(busyOk), 1);
                    checkOutput("a_ready low through frame", 32'(readyOk), 1);
                    checkOutput("busy clear after last stop", 32'(recBusy[len]), 0);
                    checkOutput("a_ready back after last stop", 32'(recReady[len]), 1);
                    expectStart = r.b2b;
                end
                monBusy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int w;
        bit idleTxdBad, idleBusyBad, idleReadyBad;
        rst   = 1'b1;
        sel   = 0;
        monEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aValid[i] = 1'b0;
            aData[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("a_ready in reset dut%0d", i), 32'(aReady[i]), 0);
            checkOutput($sformatf("txd in reset dut%0d", i), 32'(txdV[i]), 1);
            checkOutput($sformatf("busy in reset dut%0d", i), 32'(busyV[i]), 0);
        end

        rst = 1'b0;
        #1;
        checkOutput("a_ready first cycle out of reset", 32'(aReady[0]), 1);
        idleTxdBad   = 1'b0;
        idleBusyBad  = 1'b0;
        idleReadyBad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (txdV[0] !== 1'b1)   idleTxdBad   = 1'b1;
            if (busyV[0] !== 1'b0)  idleBusyBad  = 1'b1;
            if (aReady[0] !== 1'b1) idleReadyBad = 1'b1;
            @(negedge clk);
        end
        checkOutput("idle 100 cycles txd high", 32'(idleTxdBad), 0);
        checkOutput("idle 100 cycles busy low", 32'(idleBusyBad), 0);
        checkOutput("idle 100 cycles a_ready high", 32'(idleReadyBad), 0);

        monEn = 1'b1;
        sel   = 0;
        applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, w);
        drain();
        applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, w);
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, w);
        drain();

        sel = 1;
        applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, w);
        drain();
        applyStimulus(1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, w);
        drain();

        sel = 2;
        applyStimulus(2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, w);
        drain();
        applyStimulus(2, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, w);
        drain();

        sel = 3;
        applyStimulus(3, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, w);
        drain();

        // Abort 0x00 during data bit 3 (cycles 17..20 after the handshake)
        sel   = 0;
        monEn = 1'b0;
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, w);
        repeat (17) @(negedge clk);
        checkOutput("txd during data bit 3", 32'(txdV[0]), 0);
        checkOutput("busy during data bit 3", 32'(busyV[0]), 1);
        rst = 1'b1;
        #1;
        checkOutput("a_ready masked while rst", 32'(aReady[0]), 0);
        @(negedge clk);
        checkOutput("txd after abort", 32'(txdV[0]), 1);
        checkOutput("busy after abort", 32'(busyV[0]), 0);
        rst = 1'b0;
        #1;
        checkOutput("a_ready after rst drops", 32'(aReady[0]), 1);
        monEn = 1'b1;
        applyStimulus(0, 8'h96, 1'b0, 1'b0, 1'b1, 1'b1, w);
        checkOutput("handshake wait after reset", w, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiss);
        $finish;
    end

endmodule
